// File: rtl/psx_clk_reset_seq_if.sv
// Sequencer-side signal bundle for psx_clk_reset_seq.
// Signals:
//   pll_locked     PLL lock flag, asynchronous to clk1x.
//   reset_mem      active-high reset for SDRAM/memory stages.
//   reset_cpu      active-high reset for CPU/GPU/SPU core.
//   ce_sample      one-cycle 44.1 kHz clock enable.
//   running        high while the sequencer is in its run state.
//   lock_lost_cnt  saturating count of lock losses after memory came up.
// Modports:
//   slave   the sequencer: receives pll_locked and drives everything else.
//   master  the environment: drives pll_locked and observes the outputs.
interface psx_clk_reset_seq_if;
  logic       pll_locked;
  logic       reset_mem;
  logic       reset_cpu;
  logic       ce_sample;
  logic       running;
  logic [7:0] lock_lost_cnt;

  modport master (
    output pll_locked,
    input  reset_mem,
    input  reset_cpu,
    input  ce_sample,
    input  running,
    input  lock_lost_cnt
  );

  modport slave (
    input  pll_locked,
    output reset_mem,
    output reset_cpu,
    output ce_sample,
    output running,
    output lock_lost_cnt
  );
endinterface

// File: rtl/psx_clk_reset_seq.sv
// Reset sequencer and sample-tick generator downstream of the core PLL.
// Synchronises the PLL lock flag, waits for it to stay stable, releases
// the memory reset, later the CPU/core reset, then emits a one-cycle
// clock enable every SAMPLE_DIV cycles. Any lock loss returns everything
// to reset.
// Ports:
//   clk1x  33.8688 MHz PLL output clock, the only clock of the block.
//   reset  synchronous active-high reset.
//   seq    slave modport: pll_locked in; reset_mem, reset_cpu, ce_sample,
//          running and lock_lost_cnt out (all registered).
module psx_clk_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MEM_TO_CPU_CYCLES  = 16,
  parameter int SAMPLE_DIV         = 768
) (
  input  logic                clk1x,
  input  logic                reset,
  psx_clk_reset_seq_if.slave  seq
);

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > MEM_TO_CPU_CYCLES) ?
                           LOCK_STABLE_CYCLES : MEM_TO_CPU_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEM_LAST    = CNT_W'(MEM_TO_CPU_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    MEM_UP,
    RUN
  } state_t;

  logic [1:0]       sync;
  logic             locked_s;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic             ce_next;
  logic             lost_inc;

  logic             reset_mem_q;
  logic             reset_cpu_q;
  logic             ce_sample_q;
  logic             running_q;
  logic [7:0]       lost_cnt;

  // Two-flop synchroniser for the asynchronous lock flag.
  always_ff @(posedge clk1x) begin
    if (reset) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], seq.pll_locked};
    end
  end

  assign locked_s = sync[1];

  // State, counter and divider registers.
  always_ff @(posedge clk1x) begin
    if (reset) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
      div   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      div   <= div_next;
    end
  end

  // Next-state logic. Lock loss is tested before count completion so it
  // always wins. Counters fall back to zero on every state change, and the
  // divider only advances while staying in RUN, so the first tick lands a
  // full SAMPLE_DIV cycles after entering RUN. The tick is suppressed when
  // the same edge leaves RUN.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    div_next   = '0;
    ce_next    = 1'b0;
    lost_inc   = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) state_next = STABLE;
      end
      STABLE: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_next = MEM_UP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      MEM_UP: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          lost_inc   = 1'b1;
        end else if (cnt == MEM_LAST) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          lost_inc   = 1'b1;
        end else begin
          div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
          ce_next  = (div == DIV_LAST);
        end
      end
      default: begin
        state_next = WAIT_LOCK;
      end
    endcase
  end

  // Output registers, decoded from the next state so they change on the
  // same edge as the state itself. The loss counter saturates at 255.
  always_ff @(posedge clk1x) begin
    if (reset) begin
      reset_mem_q <= 1'b1;
      reset_cpu_q <= 1'b1;
      ce_sample_q <= 1'b0;
      running_q   <= 1'b0;
      lost_cnt    <= 8'd0;
    end else begin
      reset_mem_q <= (state_next == WAIT_LOCK) || (state_next == STABLE);
      reset_cpu_q <= (state_next != RUN);
      running_q   <= (state_next == RUN);
      ce_sample_q <= ce_next;
      if (lost_inc && (lost_cnt != 8'hFF)) begin
        lost_cnt <= lost_cnt + 8'd1;
      end
    end
  end

  assign seq.reset_mem     = reset_mem_q;
  assign seq.reset_cpu     = reset_cpu_q;
  assign seq.ce_sample     = ce_sample_q;
  assign seq.running       = running_q;
  assign seq.lock_lost_cnt = lost_cnt;

endmodule

// File: tb/tb_psx_clk_reset_seq.sv
// Testbench for psx_clk_reset_seq.
// Two instances: dut_a with default timing parameters and dut_b with
// minimal parameters for fast lock/loss cycling. Each has a reference
// model expressed as "consecutive cycles the sequencer has seen lock";
// every stimulus step pushes the expected outputs into a per-instance
// queue and a monitor pops and compares after each clock edge.
module tb_psx_clk_reset_seq;

  localparam int LA = 1024;
  localparam int MA = 16;
  localparam int DA = 768;
  localparam int LB = 2;
  localparam int MB = 1;
  localparam int DB = 4;

  typedef struct packed {
    logic       reset_mem;
    logic       reset_cpu;
    logic       ce_sample;
    logic       running;
    logic [7:0] lost;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  psx_clk_reset_seq_if ifa ();
  psx_clk_reset_seq_if ifb ();

  psx_clk_reset_seq #(
    .LOCK_STABLE_CYCLES (LA),
    .MEM_TO_CPU_CYCLES  (MA),
    .SAMPLE_DIV         (DA)
  ) dut_a (
    .clk1x (clk),
    .reset (rst_a),
    .seq   (ifa)
  );

  psx_clk_reset_seq #(
    .LOCK_STABLE_CYCLES (LB),
    .MEM_TO_CPU_CYCLES  (MB),
    .SAMPLE_DIV         (DB)
  ) dut_b (
    .clk1x (clk),
    .reset (rst_b),
    .seq   (ifb)
  );

  int checks   = 0;
  int failures = 0;

  exp_t qa[$];
  exp_t qb[$];
  int   steps_a = 0;
  int   steps_b = 0;
  int   pops_a  = 0;
  int   pops_b  = 0;

  // Model state: delayed lock samples and the run length of lock as seen
  // after synchronisation, plus the saturating loss count.
  bit   dly0[2];
  bit   dly1[2];
  int   mh[2];
  int   ml[2];

  // Event capture for the clean-lock timing checks on dut_a.
  bit   rec_a      = 1'b0;
  int   base_a     = 0;
  int   mem_fall_a = -1;
  int   cpu_fall_a = -1;
  int   ce_times_a[$];
  logic prev_mem_a = 1'b1;
  logic prev_cpu_a = 1'b1;

  // Reference model: lock is visible to the sequencer two edges after it
  // is sampled; after h consecutive locked edges, memory is up once
  // h > L, the core is up once h > L+M, and ticks land every D edges
  // after the core came up. A loss with memory already up is counted.
  function automatic exp_t model_step(input int w, input bit rst, input bit pll,
                                      input int l, input int m, input int d);
    exp_t e;
    bit   ls;
    if (rst) begin
      dly0[w] = 1'b0;
      dly1[w] = 1'b0;
      mh[w]   = 0;
      ml[w]   = 0;
    end else begin
      ls      = dly1[w];
      dly1[w] = dly0[w];
      dly0[w] = pll;
      if (ls) begin
        mh[w] = mh[w] + 1;
      end else begin
        if (mh[w] >= l + 1 && ml[w] < 255) ml[w] = ml[w] + 1;
        mh[w] = 0;
      end
    end
    e.reset_mem = (mh[w] < l + 1);
    e.reset_cpu = (mh[w] < l + m + 1);
    e.running   = (mh[w] >= l + m + 1);
    e.ce_sample = (mh[w] > l + m + 1) && (((mh[w] - (l + m + 1)) % d) == 0);
    e.lost      = 8'(ml[w]);
    return e;
  endfunction

  task automatic apply_stimulus(input int which, input bit rst, input bit pll);
    exp_t e;
    @(negedge clk);
    if (which == 0) begin
      rst_a          = rst;
      ifa.pll_locked = pll;
      e = model_step(0, rst, pll, LA, MA, DA);
      qa.push_back(e);
      steps_a++;
    end else begin
      rst_b          = rst;
      ifb.pll_locked = pll;
      e = model_step(1, rst, pll, LB, MB, DB);
      qb.push_back(e);
      steps_b++;
    end
  endtask

  task automatic check_output(input string name, input int idx, input exp_t e, input exp_t g);
    checks++;
    if (g !== e) begin
      failures++;
      $display("[TB] FAIL %s step=%0d got rm=%b rc=%b ce=%b run=%b lost=%0d expected rm=%b rc=%b ce=%b run=%b lost=%0d",
               name, idx, g.reset_mem, g.reset_cpu, g.ce_sample, g.running, g.lost,
               e.reset_mem, e.reset_cpu, e.ce_sample, e.running, e.lost);
    end
  endtask

  task automatic check_value(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  // Hold lock on dut_a until the model run length reaches target.
  task automatic hold_until_a(input int target, input int limit);
    int n;
    n = 0;
    while (mh[0] != target && n < limit) begin
      apply_stimulus(0, 1'b0, 1'b1);
      n++;
    end
    checks++;
    if (mh[0] != target) begin
      failures++;
      $display("[TB] FAIL hold_until_a got=%0d expected=%0d", mh[0], target);
    end
  endtask

  // Monitor for dut_a, including event capture for the timing checks.
  always @(posedge clk) begin
    exp_t ea;
    exp_t ga;
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      ga.reset_mem = ifa.reset_mem;
      ga.reset_cpu = ifa.reset_cpu;
      ga.ce_sample = ifa.ce_sample;
      ga.running   = ifa.running;
      ga.lost      = ifa.lock_lost_cnt;
      check_output("dut_a", pops_a, ea, ga);
      if (rec_a && pops_a >= base_a) begin
        if (prev_mem_a && !ifa.reset_mem && mem_fall_a < 0) mem_fall_a = pops_a - base_a;
        if (prev_cpu_a && !ifa.reset_cpu && cpu_fall_a < 0) cpu_fall_a = pops_a - base_a;
        if (ifa.ce_sample && ce_times_a.size() < 3) ce_times_a.push_back(pops_a - base_a);
      end
      prev_mem_a = ifa.reset_mem;
      prev_cpu_a = ifa.reset_cpu;
      pops_a++;
    end
  end

  // Monitor for dut_b.
  always @(posedge clk) begin
    exp_t eb;
    exp_t gb;
    #1;
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      gb.reset_mem = ifb.reset_mem;
      gb.reset_cpu = ifb.reset_cpu;
      gb.ce_sample = ifb.ce_sample;
      gb.running   = ifb.running;
      gb.lost      = ifb.lock_lost_cnt;
      check_output("dut_b", pops_b, eb, gb);
      pops_b++;
    end
  end

  task automatic run_a();
    int  hi_len;
    int  lo_len;
    bit  rbit;
    // Clean lock from reset.
    repeat (4) apply_stimulus(0, 1'b1, 1'b0);
    rec_a  = 1'b1;
    base_a = steps_a;
    repeat (3400) apply_stimulus(0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rec_a = 1'b0;
    check_value("mem_fall_edge", mem_fall_a, 2 + LA);
    check_value("cpu_fall_edge", cpu_fall_a, 2 + LA + MA);
    check_value("ce_count", ce_times_a.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < ce_times_a.size()) check_value("ce_edge", ce_times_a[k], 2 + LA + MA + (k + 1) * DA);
    end
    // Loss in RUN, then a short glitch while still in STABLE.
    repeat (5) apply_stimulus(0, 1'b0, 1'b0);
    repeat (500) apply_stimulus(0, 1'b0, 1'b1);
    repeat (3) apply_stimulus(0, 1'b0, 1'b0);
    repeat (1100) apply_stimulus(0, 1'b0, 1'b1);
    // Loss arriving on the edge that would have produced a tick.
    hold_until_a(LA + MA + 1 + DA - 3, 3000);
    repeat (6) apply_stimulus(0, 1'b0, 1'b0);
    // Loss arriving on the MEM_UP count-complete edge.
    hold_until_a(LA + MA + 1 - 3, 3000);
    repeat (6) apply_stimulus(0, 1'b0, 1'b0);
    // Synchronous reset while running with lock held.
    hold_until_a(LA + MA + 50, 3000);
    repeat (2) apply_stimulus(0, 1'b1, 1'b1);
    repeat (1100) apply_stimulus(0, 1'b0, 1'b1);
    // Randomised lock/loss segments with occasional resets.
    for (int s = 0; s < 20; s++) begin
      hi_len = int'($urandom_range(1, 1500));
      lo_len = int'($urandom_range(1, 8));
      repeat (hi_len) apply_stimulus(0, 1'b0, 1'b1);
      repeat (lo_len) apply_stimulus(0, 1'b0, 1'b0);
      if ($urandom_range(0, 9) == 0) begin
        rbit = 1'($urandom_range(0, 1));
        apply_stimulus(0, 1'b1, rbit);
      end
    end
  endtask

  task automatic run_b();
    bit pll;
    bit rbit;
    repeat (2) apply_stimulus(1, 1'b1, 1'b0);
    // Enough lock/loss cycles to saturate the loss counter.
    for (int c = 0; c < 300; c++) begin
      repeat (8) apply_stimulus(1, 1'b0, 1'b1);
      repeat (4) apply_stimulus(1, 1'b0, 1'b0);
    end
    @(posedge clk);
    #2;
    check_value("b_saturation", int'(ifb.lock_lost_cnt), 255);
    // Random lock flag with persistence and rare resets.
    pll = 1'b1;
    for (int s = 0; s < 1500; s++) begin
      if ($urandom_range(0, 3) == 0) pll = ~pll;
      rbit = ($urandom_range(0, 59) == 0);
      apply_stimulus(1, rbit, pll);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    ifa.pll_locked = 1'b0;
    ifb.pll_locked = 1'b0;
    fork
      run_a();
      run_b();
    join
    repeat (2) @(posedge clk);
    #2;
    check_value("qa_drained", qa.size(), 0);
    check_value("qb_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
